// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file bank: clear-FSM states and address width.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clearState_t;

    // Address width is clog2 of the register count, but never narrower than one bit.
    function automatic int unsigned addrWidth(input int unsigned nRegs);
        int unsigned w;
        w = $clog2(nRegs);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear-sweep controller: walks an index over every register, one per cycle, then pulses done.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter  int unsigned N_REGS = 32,
    localparam int unsigned ADDR_W = addrWidth(N_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clearReq,
    output logic [ADDR_W-1:0] sweepIdx,
    output logic              sweepWr_c,
    output logic              fsmIdle_c,
    output logic              clearBusy,
    output logic              clearDone
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_REGS - 1);

    clearState_t       state;
    clearState_t       stateNext;
    logic [ADDR_W-1:0] idxNext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sweepIdx  <= '0;
            clearBusy <= 1'b0;
            clearDone <= 1'b0;
        end else begin
            state     <= stateNext;
            sweepIdx  <= idxNext;
            clearBusy <= (stateNext != IDLE);
            clearDone <= (stateNext == DONE);
        end
    end

    always_comb begin
        stateNext = state;
        idxNext   = sweepIdx;
        sweepWr_c = 1'b0;
        fsmIdle_c = 1'b0;
        case (state)
            IDLE: begin
                fsmIdle_c = 1'b1;
                if (clearReq) begin
                    stateNext = CLEAR;
                    idxNext   = '0;
                end
            end
            CLEAR: begin
                sweepWr_c = 1'b1;
                // Hold the index at the last register so it never wraps.
                if (sweepIdx == LAST_IDX) begin
                    stateNext = DONE;
                end else begin
                    idxNext = sweepIdx + ADDR_W'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
                idxNext   = '0;
            end
            default: begin
                stateNext = IDLE;
                idxNext   = '0;
            end
        endcase
    end

endmodule

// File: rtl/register_file_bank.sv
// Two-read, one-write register file with optional zero register, write forwarding
// and a sequential clear sweep.
module register_file_bank
    import regfile_pkg::*;
#(
    parameter  int unsigned N_BITS   = 32,
    parameter  int unsigned N_REGS   = 32,
    parameter  int unsigned ZERO_REG = 1,
    parameter  int unsigned BYPASS   = 1,
    localparam int unsigned ADDR_W   = addrWidth(N_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [N_BITS-1:0] write_data,
    input  logic [ADDR_W-1:0] read_register1,
    input  logic [ADDR_W-1:0] read_register2,
    output logic [N_BITS-1:0] read_data1,
    output logic [N_BITS-1:0] read_data2,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
);

    localparam logic [ADDR_W:0] REG_COUNT = (ADDR_W + 1)'(N_REGS);

    logic [N_BITS-1:0] regs [N_REGS];
    logic [ADDR_W-1:0] sweepIdx;
    logic              sweepWr_c;
    logic              fsmIdle_c;
    logic              writeAccept_c;

    // An address is live when it names an existing register that is not the hard zero.
    function automatic logic addrValid(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < REG_COUNT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    regfile_clear_ctrl #(
        .N_REGS (N_REGS)
    ) u_clearCtrl (
        .clk       (clk),
        .reset     (reset),
        .clearReq  (clear_req),
        .sweepIdx  (sweepIdx),
        .sweepWr_c (sweepWr_c),
        .fsmIdle_c (fsmIdle_c),
        .clearBusy (clear_busy),
        .clearDone (clear_done)
    );

    assign writeAccept_c = reg_write && fsmIdle_c && addrValid(write_register);

    // Sweep and normal writes are exclusive: writes are only accepted while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (sweepWr_c) begin
            regs[sweepIdx] <= '0;
        end else if (writeAccept_c) begin
            regs[write_register] <= write_data;
        end
    end

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (addrValid(read_register1)) begin
            if ((BYPASS != 0) && writeAccept_c && (write_register == read_register1)) begin
                read_data1 = write_data;
            end else begin
                read_data1 = regs[read_register1];
            end
        end
        if (addrValid(read_register2)) begin
            if ((BYPASS != 0) && writeAccept_c && (write_register == read_register2)) begin
                read_data2 = write_data;
            end else begin
                read_data2 = regs[read_register2];
            end
        end
    end

endmodule
